// File: rtl/seg_scan_mux_if.sv
// Display-side bundle for seg_scan_mux: value capture inputs and the scanned
// active-low anode/segment outputs.
interface seg_scan_mux_if #(
  parameter int unsigned DIGITS = 2
);
  logic [4*DIGITS-1:0] din;
  logic                din_valid;
  logic                hold;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                frame_done;

  modport master (
    output din,
    output din_valid,
    output hold,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  din,
    input  din_valid,
    input  hold,
    output an,
    output seg,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-slot dead time and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_mux #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  seg_scan_mux_if.slave  io_bus
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DinW = 4 * DIGITS;

  logic [DinW-1:0]   r_shadow;
  logic [DinW-1:0]   r_disp;
  logic [CntW-1:0]   r_cnt;
  logic [IdxW-1:0]   r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_frame_done;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_blank;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_lead_zero;
  logic [DIGITS-1:0] w_an_d;
  logic [6:0]        w_seg_d;

  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_slot_end  = (r_cnt == CntW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IdxW'(DIGITS - 1));
  assign w_blank     = (32'(r_cnt) < DEAD);
  assign w_nib       = r_disp[4*r_idx +: 4];

`ifdef SEG_SCAN_LZB_EN
  // Digit k>0 is blank when it and every higher nibble are zero; digit 0 never blanks.
  logic w_zero_run;
  always_comb begin
    w_lead_zero = '0;
    w_zero_run  = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      w_zero_run     = w_zero_run && (r_disp[4*k +: 4] == 4'h0);
      w_lead_zero[k] = w_zero_run;
    end
  end
`else
  assign w_lead_zero = '0;
`endif

  always_comb begin
    w_an_d  = '1;
    w_seg_d = 7'h7F;
    if (!w_blank && !w_lead_zero[r_idx]) begin
      w_an_d[r_idx] = 1'b0;
      w_seg_d       = hexdec(w_nib);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow     <= '0;
      r_disp       <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      if (io_bus.din_valid && !io_bus.hold) begin
        r_shadow <= io_bus.din;
      end
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
      // Pre-edge shadow is taken, so a capture on this same cycle waits a frame.
      if (w_frame_end) begin
        r_disp <= r_shadow;
      end
      r_frame_done <= w_frame_end;
      r_an         <= w_an_d;
      r_seg        <= w_seg_d;
    end
  end

  assign io_bus.an         = r_an;
  assign io_bus.seg        = r_seg;
  assign io_bus.frame_done = r_frame_done;

endmodule
